// File: rtl/vga_frame_monitor.sv
// Rebuilds pixel coordinates from registered syncs, verifies raster timing, locks, and samples 16 cell centres per frame.
// Latency: one input register stage, cell readout one cycle; no backpressure, the pixel stream is never stalled.
module vga_frame_monitor #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 526,
    parameter int CELL_X0    = 355,
    parameter int CELL_Y0    = 165,
    parameter int CELL_PITCH = 75
) (
    input  logic        VGA_CLK_IN,
    input  logic        rst_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    input  logic [3:0]  i_cell_sel,
    output logic [23:0] o_cell_rgb,
    output logic        o_locked,
    output logic        o_timing_err,
    output logic        o_frame_done,
    output logic [9:0]  o_line_len,
    output logic [9:0]  o_frame_lines,
    output logic [7:0]  o_frame_count
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0] H_LEN   = 10'(H_TOTAL);
    localparam logic [9:0] V_LEN   = 10'(V_TOTAL);
    localparam logic [9:0] SAT     = 10'd1023;
    localparam logic [9:0] SAT_M1  = 10'd1022;

    state_t      state, state_next;

    logic        hs_s1, vs_s1;
    logic [23:0] rgb_s1;
    logic        hs_prev;
    logic        vs_line;
    logic        seen_h;
    logic [9:0]  x_prev;
    logic [9:0]  x;
    logic [9:0]  y;

    logic        hrise, vrise;
    logic        x_loss, y_loss;
    logic [9:0]  line_len_new, frame_lines_new;
    logic        line_ok, frame_ok;
    logic        err, publish;

    logic        cap_hit;
    logic [3:0]  cap_idx;
    logic        cap_en;

    logic [23:0] shadow  [16];
    logic [23:0] visible [16];

    assign hrise = hs_s1 & ~hs_prev;
    assign vrise = hrise & vs_s1 & ~vs_line;

    // x is the coordinate of the sample currently held in the input stage
    assign x = hrise ? 10'd0 : ((x_prev == SAT) ? SAT : x_prev + 10'd1);

    // Loss of sync fires only on the transition into saturation, so it pulses once
    assign x_loss = !hrise && (x_prev == SAT_M1);
    assign y_loss = hrise && !vrise && (y == SAT_M1);

    assign line_len_new    = x_prev + 10'd1;
    assign frame_lines_new = y + 10'd1;
    assign line_ok         = seen_h && (line_len_new == H_LEN);
    assign frame_ok        = (frame_lines_new == V_LEN);

    assign o_locked = (state == LOCKED);

    always_comb begin
        cap_hit = 1'b0;
        cap_idx = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (x == 10'(CELL_X0 + c * CELL_PITCH) &&
                    y == 10'(CELL_Y0 + r * CELL_PITCH)) begin
                    cap_hit = 1'b1;
                    cap_idx = 4'(r * 4 + c);
                end
            end
        end
    end

    assign cap_en = cap_hit && (state == LOCKED);

    always_comb begin
        state_next = state;
        err        = 1'b0;
        publish    = 1'b0;
        if (x_loss || y_loss) begin
            state_next = SEARCH;
            err        = 1'b1;
        end else if (hrise) begin
            case (state)
                SEARCH: begin
                    if (vrise) begin
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (vrise) begin
                        if (line_ok && frame_ok) begin
                            state_next = LOCKED;
                        end else begin
                            err = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!line_ok || (vrise && !frame_ok)) begin
                        err        = 1'b1;
                        state_next = MEASURE;
                    end else if (vrise) begin
                        publish = 1'b1;
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1         <= 1'b0;
            vs_s1         <= 1'b0;
            rgb_s1        <= 24'd0;
            hs_prev       <= 1'b0;
            vs_line       <= 1'b0;
            seen_h        <= 1'b0;
            x_prev        <= 10'd0;
            y             <= 10'd0;
            o_line_len    <= 10'd0;
            o_frame_lines <= 10'd0;
            o_timing_err  <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_count <= 8'd0;
        end else begin
            hs_s1        <= i_hsync;
            vs_s1        <= i_vsync;
            rgb_s1       <= {i_red, i_green, i_blue};
            hs_prev      <= hs_s1;
            x_prev       <= x;
            o_timing_err <= err;
            o_frame_done <= publish;
            if (hrise) begin
                seen_h  <= 1'b1;
                vs_line <= vs_s1;
                // The first hrise after reset has no complete line behind it
                if (seen_h) begin
                    o_line_len <= line_len_new;
                end
                if (vrise) begin
                    o_frame_lines <= frame_lines_new;
                    y             <= 10'd0;
                end else if (y != SAT) begin
                    y <= y + 10'd1;
                end
            end
            if (publish) begin
                o_frame_count <= o_frame_count + 8'd1;
            end
        end
    end

    // Readout samples the visible bank before any same-edge publish lands
    always_ff @(posedge VGA_CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                shadow[i]  <= 24'd0;
                visible[i] <= 24'd0;
            end
            o_cell_rgb <= 24'd0;
        end else begin
            if (cap_en) begin
                shadow[cap_idx] <= rgb_s1;
            end
            if (publish) begin
                for (int i = 0; i < 16; i++) begin
                    visible[i] <= shadow[i];
                end
            end
            o_cell_rgb <= visible[i_cell_sel];
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a reduced raster (80 x 32) so that many frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_frame_monitor;

    localparam int HT = 80;
    localparam int VT = 32;
    localparam int X0 = 30;
    localparam int Y0 = 4;
    localparam int P  = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [7:0]  red = 8'd0;
    logic [7:0]  green = 8'd0;
    logic [7:0]  blue = 8'd0;
    logic [3:0]  cell_sel = 4'd0;
    logic [23:0] cell_rgb;
    logic        locked;
    logic        timing_err;
    logic        frame_done;
    logic [9:0]  line_len;
    logic [9:0]  frame_lines;
    logic [7:0]  frame_count;

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    vga_frame_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .CELL_X0(X0), .CELL_Y0(Y0), .CELL_PITCH(P)
    ) dut (
        .VGA_CLK_IN    (clk),
        .rst_n         (rst_n),
        .i_hsync       (hsync),
        .i_vsync       (vsync),
        .i_red         (red),
        .i_green       (green),
        .i_blue        (blue),
        .i_cell_sel    (cell_sel),
        .o_cell_rgb    (cell_rgb),
        .o_locked      (locked),
        .o_timing_err  (timing_err),
        .o_frame_done  (frame_done),
        .o_line_len    (line_len),
        .o_frame_lines (frame_lines),
        .o_frame_count (frame_count)
    );

    always @(negedge clk) begin
        if (timing_err) err_seen++;
        if (frame_done) done_seen++;
    end

    function automatic logic [23:0] cell_colour(input int i);
        if (i == 0)  return 24'hCCFF99;
        if (i == 15) return 24'h00FF00;
        return 24'(32'h101010 * i);
    endfunction

    function automatic logic [23:0] pix(input int l, input int k);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (l == Y0 + r * P && k == X0 + c * P) return cell_colour(r * 4 + c);
        return 24'h0A0B0C;
    endfunction

    task automatic send_line(input int len, input logic vs, input int l);
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            hsync = (k < 8);
            vsync = vs;
            {red, green, blue} = pix(l, k);
        end
    endtask

    // Sends lines 2..lines-1 of the current frame, then lines 0 and 1 of the next,
    // so on return the vsync edge that closes this frame has been evaluated.
    task automatic send_frame(input int lines, input int short_idx);
        for (int l = 2; l < lines; l++) send_line((l == short_idx) ? HT - 1 : HT, 1'b0, l);
        send_line(HT, 1'b1, 0);
        send_line(HT, 1'b1, 1);
    endtask

    task automatic read_cell(input int i, output logic [23:0] rgb);
        @(posedge clk); #1;
        cell_sel = 4'(i);
        @(posedge clk);
        @(negedge clk);
        rgb = cell_rgb;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({locked, timing_err, frame_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, want 000", {locked, timing_err, frame_done});
        end
        vectors++;
        if ({line_len, frame_lines, frame_count} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_counters: got len=%0d lines=%0d cnt=%0d, want 0", line_len, frame_lines, frame_count);
        end
        vectors++;
        if (cell_rgb !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_rgb: got %h, want 000000", cell_rgb);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lock;
        send_line(HT, 1'b1, 0);
        send_line(HT, 1'b1, 1);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_first_vrise: locked=%b, want 0", locked);
        end
        send_frame(VT, -1);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_second_vrise: locked=%b, want 1", locked);
        end
        vectors++;
        if (line_len !== 10'(HT) || frame_lines !== 10'(VT)) begin
            miscompares++;
            $display("FAIL lock_lengths: got %0d x %0d, want %0d x %0d", line_len, frame_lines, HT, VT);
        end
        vectors++;
        if (err_seen !== 0 || done_seen !== 0) begin
            miscompares++;
            $display("FAIL lock_pulses: err=%0d done=%0d, want 0 0", err_seen, done_seen);
        end
    endtask

    task automatic test_publish;
        logic [23:0] rgb;
        send_frame(VT, -1);
        vectors++;
        if (done_seen !== 1 || frame_count !== 8'd1) begin
            miscompares++;
            $display("FAIL publish_first: done=%0d cnt=%0d, want 1 1", done_seen, frame_count);
        end
        fork
            send_frame(VT, -1);
            begin
                for (int i = 0; i < 16; i++) begin
                    read_cell(i, rgb);
                    vectors++;
                    if (rgb !== cell_colour(i)) begin
                        miscompares++;
                        $display("FAIL cell_%0d: got %h, want %h", i, rgb, cell_colour(i));
                    end
                end
            end
        join
        vectors++;
        if (done_seen !== 2 || frame_count !== 8'd2) begin
            miscompares++;
            $display("FAIL publish_second: done=%0d cnt=%0d, want 2 2", done_seen, frame_count);
        end
    endtask

    task automatic test_short_line;
        int e0;
        logic found;
        logic [23:0] rgb;
        e0 = err_seen;
        found = 1'b0;
        fork
            send_frame(VT, 10);
            begin
                for (int n = 0; n < 3000; n++) begin
                    @(negedge clk);
                    if (timing_err) begin
                        found = 1'b1;
                        break;
                    end
                end
                vectors++;
                if (!found || locked !== 1'b0 || line_len !== 10'(HT - 1)) begin
                    miscompares++;
                    $display("FAIL short_line_err: seen=%b locked=%b len=%0d, want 1 0 %0d", found, locked, line_len, HT - 1);
                end
                read_cell(0, rgb);
                vectors++;
                if (rgb !== 24'hCCFF99) begin
                    miscompares++;
                    $display("FAIL short_line_keep0: got %h, want ccff99", rgb);
                end
                read_cell(15, rgb);
                vectors++;
                if (rgb !== 24'h00FF00) begin
                    miscompares++;
                    $display("FAIL short_line_keep15: got %h, want 00ff00", rgb);
                end
            end
        join
        vectors++;
        if (err_seen - e0 !== 1 || frame_count !== 8'd2) begin
            miscompares++;
            $display("FAIL short_line_count: errs=%0d cnt=%0d, want 1 2", err_seen - e0, frame_count);
        end
        send_frame(VT, -1);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL short_line_relock: locked=%b, want 1", locked);
        end
    endtask

    task automatic test_sync_loss;
        int e0;
        e0 = err_seen;
        for (int k = 0; k < 1100; k++) begin
            @(posedge clk); #1;
            hsync = 1'b0;
            vsync = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (err_seen - e0 !== 1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_loss: errs=%0d locked=%b, want 1 0", err_seen - e0, locked);
        end
    endtask

    task automatic test_short_frame;
        int e0;
        e0 = err_seen;
        send_line(HT, 1'b0, 2);
        send_line(HT, 1'b1, 0);
        send_line(HT, 1'b1, 1);
        send_frame(VT - 1, -1);
        vectors++;
        if (err_seen - e0 !== 1 || locked !== 1'b0 || frame_lines !== 10'(VT - 1)) begin
            miscompares++;
            $display("FAIL short_frame: errs=%0d locked=%b lines=%0d, want 1 0 %0d", err_seen - e0, locked, frame_lines, VT - 1);
        end
        send_frame(VT, -1);
        vectors++;
        if (err_seen - e0 !== 1 || locked !== 1'b1 || frame_lines !== 10'(VT)) begin
            miscompares++;
            $display("FAIL short_frame_relock: errs=%0d locked=%b lines=%0d, want 1 1 %0d", err_seen - e0, locked, frame_lines, VT);
        end
    endtask

    task automatic test_reset_midframe;
        logic [23:0] rgb;
        fork
            send_frame(VT, -1);
            begin
                repeat (500) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                vectors++;
                if ({locked, timing_err, frame_done, line_len, frame_lines, frame_count, cell_rgb} !== 55'd0) begin
                    miscompares++;
                    $display("FAIL async_reset: locked=%b len=%0d lines=%0d cnt=%0d rgb=%h, want all 0",
                             locked, line_len, frame_lines, frame_count, cell_rgb);
                end
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    read_cell(i, rgb);
                    vectors++;
                    if (rgb !== 24'd0) begin
                        miscompares++;
                        $display("FAIL post_reset_cell_%0d: got %h, want 000000", i, rgb);
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_lock();
        test_publish();
        test_short_line();
        test_sync_loss();
        test_short_frame();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
- Receive-side checker for the VGA pixel stream produced by our display sync/renderer.
- Sits on the pixel clock and rebuilds pixel coordinates from i_hsync/i_vsync.
- Checks line and frame timing against the nominal 800 x 526 raster, then locks.
- While locked, samples the colour at the centre of each of the 16 board cells (4x4 grid) once per frame, so the bench or a self-test path can read back what was drawn.

Parameters:
H_TOTAL, 800, clocks per line (hsync rise to hsync rise)
V_TOTAL, 526, lines per frame (vsync rise to vsync rise)
CELL_X0, 355, x coordinate of column-0 cell centre
CELL_Y0, 165, y coordinate of row-0 cell centre
CELL_PITCH, 75, centre-to-centre spacing in x and y

Ports:
VGA_CLK_IN  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_hsync  in  1  horizontal sync, active-high pulse
i_vsync  in  1  vertical sync, active-high pulse
i_red  in  8  pixel red
i_green  in  8  pixel green
i_blue  in  8  pixel blue
i_cell_sel  in  4  cell index for readout, index = row*4 + col
o_cell_rgb  out  24  {r,g,b} of the selected cell from the last completed frame
o_locked  out  1  high while timing is verified
o_timing_err  out  1  one-cycle pulse on a timing mismatch
o_frame_done  out  1  one-cycle pulse when a new cell bank is published
o_line_len  out  10  last measured line length in clocks
o_frame_lines  out  10  last measured frame length in lines
o_frame_count  out  8  count of published frames, wraps 255 to 0

Behaviour:
- Reset (async assert, sync release): all outputs 0, all 16 shadow and visible cell entries 0, counters 0, state SEARCH.
- Input stage: hsync, vsync and rgb are registered once (stage S1). hs_prev and vs_line hold history for edge detection.
- hrise: hs_S1=1 and hs_prev=0.
- x counter (coordinate of the S1 sample):
  - 0 on the hrise cycle, +1 per clock after.
  - Saturates at 1023. Reaching 1023 is the loss-of-sync condition.
- On each hrise:
  - o_line_len <= x_prev+1 (the clock count of the previous line). Not updated on the first hrise after reset.
  - vrise is a line-level edge: vs_S1=1 at this hrise and vs_S1=0 at the previous hrise.
  - If vrise: o_frame_lines <= y+1 and y <= 0. Otherwise y <= y+1, saturating at 1023.
- FSM:
  - SEARCH: wait for vrise, then go to MEASURE. o_locked=0.
  - MEASURE: at the next vrise, if o_line_len==H_TOTAL and the frame line count==V_TOTAL, go to LOCKED. Otherwise pulse o_timing_err and stay in MEASURE.
  - LOCKED: o_locked=1. At every vrise, check line and frame lengths.
    - Match: copy shadow to visible, pulse o_frame_done, o_frame_count+1.
    - Mismatch: pulse o_timing_err, go to MEASURE, no publish.
  - Any state: x reaching 1023 or y reaching 1023 pulses o_timing_err once and forces SEARCH. o_locked drops the next cycle.
  - Line-length check also runs at every hrise in LOCKED. A mismatch there acts like a frame mismatch.
- Cell capture (LOCKED only):
  - When x == CELL_X0 + c*CELL_PITCH and y == CELL_Y0 + r*CELL_PITCH (r,c in 0..3), write S1 rgb into shadow[r*4+c].
  - At most one capture per cycle. Shadow is not cleared between frames.
- Publish: copying shadow to visible happens on the same edge that pulses o_frame_done.
  - The first LOCKED-entry vrise publishes nothing, because the shadow was not captured under lock.
  - Publishing starts from the second vrise in LOCKED.
- Readout: o_cell_rgb <= visible[i_cell_sel], 1-cycle registered latency.
  - If a publish and a read hit the same cycle, the read returns the pre-publish value; the new value appears the next cycle.
- Simultaneous hrise and loss-of-sync saturation: SEARCH wins.
- Reset mid-frame discards everything. Re-lock requires SEARCH, then one full MEASURE frame.
- Widths: x and y are 10-bit, comparisons unsigned. Cell-centre constants are computed at elaboration and must be < 1023.

Test Plan:
- Nominal 800x526 source, hsync high at x 0-95, vsync high on lines 0-1, cells filled with 16 distinct colours -> o_locked rises at the 2nd vrise, o_line_len=800, o_frame_lines=526, no o_timing_err.
- Same source, third frame -> o_frame_done pulses once per frame. Reading i_cell_sel=0..15 returns the 16 programmed colours, e.g. cell 0 = 24'hCCFF99 and cell 15 = 24'h00FF00. o_frame_count increments by 1 per frame.
- While locked, one line shortened to 799 clocks -> o_timing_err pulse at that hrise, o_locked=0. Visible bank retains its previous contents. Re-lock after one clean MEASURE frame.
- hsync held low for 1100 clocks -> single o_timing_err pulse at x=1023, state SEARCH, o_locked=0.
- Frame of 525 lines in MEASURE -> o_timing_err, stays unlocked. Next 526-line frame -> o_locked=1.
- rst_n asserted mid-frame while locked -> all outputs 0 asynchronously, and o_cell_rgb reads 0 for every index after release.
